// File: rtl/eth_rx_ring_if.sv
// Byte-wide AXI-Stream receive channel from the MAC into the receive ring.
interface eth_rx_ring_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;
    logic       tready;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_rx_ring.sv
// Ethernet receive ring: destination filtering, NBUF fixed-size frame slots
// with committed lengths, per-cause drop counters and a word-wide host port.
// The slot-free strobe is called release_req because 'release' is a reserved
// word in SystemVerilog.
module eth_rx_ring #(
    parameter  int NBUF      = 8,
    parameter  int BUF_BYTES = 2048,
    parameter  int DATA_W    = 64,
    localparam int SLOT_W    = $clog2(NBUF),
    localparam int OFF_W     = $clog2(BUF_BYTES),
    localparam int LANES     = DATA_W / 8,
    localparam int LANE_W    = $clog2(LANES),
    localparam int ADDR_W    = SLOT_W + OFF_W - LANE_W
) (
    input  logic              clk_int,
    input  logic              rst_int_n,
    eth_rx_ring_if.slave      s_axis,
    input  logic [47:0]       mac_address,
    input  logic              promiscuous,
    input  logic              irq_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic [SLOT_W-1:0] len_idx,
    output logic [15:0]       len_data,
    input  logic              release_req,
    output logic [SLOT_W-1:0] head,
    output logic [SLOT_W-1:0] tail,
    output logic [SLOT_W:0]   count,
    output logic              irq,
    output logic [15:0]       drop_full,
    output logic [15:0]       drop_filter,
    output logic [15:0]       drop_err
);

    localparam int CNT_W  = OFF_W + 1;
    localparam int NWORDS = NBUF * BUF_BYTES / LANES;

    typedef enum logic [2:0] {IDLE, HDR, BODY, COMMIT, DISCARD} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bytecnt_q, bytecnt_d;
    logic [39:0]         dest_mac_q, dest_mac_d;
    logic [SLOT_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [SLOT_W:0]     count_q, count_d;
    logic                irq_q, irq_d;
    logic [15:0]         drop_full_q, drop_full_d;
    logic [15:0]         drop_filter_q, drop_filter_d;
    logic [15:0]         drop_err_q, drop_err_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [15:0]         len_data_q, len_data_d;
    logic [15:0]         len_q [NBUF];

    logic [LANES-1:0][7:0] mem [NWORDS];

    logic                xfer, accept, rel_ok;
    logic                inc_full, inc_filter, inc_err;
    logic                mem_we, len_we;
    logic [OFF_W-1:0]    mem_off;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [LANE_W-1:0]   mem_lane;
    logic [CNT_W-1:0]    bc_inc;
    logic [47:0]         hdr_mac;

    assign s_axis.tready = (state_q != COMMIT);
    assign xfer      = s_axis.tvalid & s_axis.tready;
    assign bc_inc    = bytecnt_q + CNT_W'(1);
    // Destination as it stands once the current byte is shifted in; only
    // meaningful on the 6th header byte.
    assign hdr_mac   = {dest_mac_q, s_axis.tdata};
    assign accept    = promiscuous | (hdr_mac == mac_address) | (hdr_mac == 48'hFFFF_FFFF_FFFF)
                     | (hdr_mac[47:24] == 24'h01005E);
    assign mem_waddr = {tail_q, mem_off[OFF_W-1:LANE_W]};
    assign mem_lane  = mem_off[LANE_W-1:0];

    // Receive FSM, ring pointers, occupancy and drop bookkeeping.
    always_comb begin
        state_d    = state_q;
        bytecnt_d  = bytecnt_q;
        dest_mac_d = dest_mac_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        inc_full   = 1'b0;
        inc_filter = 1'b0;
        inc_err    = 1'b0;
        mem_we     = 1'b0;
        mem_off    = bytecnt_q[OFF_W-1:0];
        len_we     = 1'b0;
        case (state_q)
            IDLE: if (xfer) begin
                if (count_q == (SLOT_W+1)'(NBUF)) begin
                    inc_full = 1'b1;
                    if (!s_axis.tlast) state_d = DISCARD;
                end else begin
                    mem_we     = 1'b1;
                    mem_off    = '0;
                    bytecnt_d  = CNT_W'(1);
                    dest_mac_d = {32'd0, s_axis.tdata};
                    if (s_axis.tlast) inc_err = 1'b1;
                    else              state_d = HDR;
                end
            end
            HDR: if (xfer) begin
                mem_we     = 1'b1;
                bytecnt_d  = bc_inc;
                dest_mac_d = {dest_mac_q[31:0], s_axis.tdata};
                if (bytecnt_q == CNT_W'(5)) begin
                    if (!accept) begin
                        inc_filter = 1'b1;
                        state_d    = s_axis.tlast ? IDLE : DISCARD;
                    end else if (s_axis.tlast) begin
                        // A frame ending exactly on the address is handled
                        // like any other tlast in the body.
                        if (s_axis.tuser) begin
                            inc_err = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = COMMIT;
                        end
                    end else begin
                        state_d = BODY;
                    end
                end else if (s_axis.tlast) begin
                    inc_err = 1'b1;
                    state_d = IDLE;
                end
            end
            BODY: if (xfer) begin
                mem_we    = 1'b1;
                bytecnt_d = bc_inc;
                if (s_axis.tlast) begin
                    if (s_axis.tuser) begin
                        inc_err = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = COMMIT;
                    end
                end else if (bc_inc == CNT_W'(BUF_BYTES)) begin
                    inc_err = 1'b1;
                    state_d = DISCARD;
                end
            end
            COMMIT: begin
                len_we  = 1'b1;
                tail_d  = tail_q + SLOT_W'(1);
                state_d = IDLE;
            end
            DISCARD: if (xfer && s_axis.tlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rel_ok = release_req && (count_q != '0);
        if (rel_ok) head_d = head_q + SLOT_W'(1);
        case ({len_we, rel_ok})
            2'b10:   count_d = count_q + (SLOT_W+1)'(1);
            2'b01:   count_d = count_q - (SLOT_W+1)'(1);
            default: count_d = count_q;
        endcase

        drop_full_d   = (inc_full   && drop_full_q   != 16'hFFFF) ? drop_full_q   + 16'd1 : drop_full_q;
        drop_filter_d = (inc_filter && drop_filter_q != 16'hFFFF) ? drop_filter_q + 16'd1 : drop_filter_q;
        drop_err_d    = (inc_err    && drop_err_q    != 16'hFFFF) ? drop_err_q    + 16'd1 : drop_err_q;
    end

    // Host-side registered views: read word, slot length, interrupt.
    always_comb begin
        rd_data_d  = rd_en ? mem[rd_addr] : rd_data_q;
        len_data_d = len_q[len_idx];
        irq_d      = irq_en & (count_q != '0);
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk_int or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q       <= IDLE;
            bytecnt_q     <= '0;
            dest_mac_q    <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            irq_q         <= 1'b0;
            drop_full_q   <= '0;
            drop_filter_q <= '0;
            drop_err_q    <= '0;
            rd_data_q     <= '0;
            len_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            bytecnt_q     <= bytecnt_d;
            dest_mac_q    <= dest_mac_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            irq_q         <= irq_d;
            drop_full_q   <= drop_full_d;
            drop_filter_q <= drop_filter_d;
            drop_err_q    <= drop_err_d;
            rd_data_q     <= rd_data_d;
            len_data_q    <= len_data_d;
        end
    end

    // Committed length table, written in the COMMIT cycle.
    always_ff @(posedge clk_int or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < NBUF; i++) len_q[i] <= '0;
        end else if (len_we) begin
            len_q[tail_q] <= 16'(bytecnt_q);
        end
    end

    // Frame RAM write port, one byte lane per transfer; contents not reset.
    always_ff @(posedge clk_int) begin
        if (mem_we) mem[mem_waddr][mem_lane] <= s_axis.tdata;
    end

    assign rd_data     = rd_data_q;
    assign len_data    = len_data_q;
    assign head        = head_q;
    assign tail        = tail_q;
    assign count       = count_q;
    assign irq         = irq_q;
    assign drop_full   = drop_full_q;
    assign drop_filter = drop_filter_q;
    assign drop_err    = drop_err_q;

endmodule

// File: tb/tb_eth_rx_ring.sv
// Randomised bench for eth_rx_ring with a frame-level reference model.
module tb_eth_rx_ring;
    localparam int NBUF = 8, BUF_BYTES = 2048, DATA_W = 64;
    localparam int SLOT_W = 3, ADDR_W = 11, WPS = BUF_BYTES / 8;
    localparam logic [47:0] MAC = 48'h230100890702;

    logic clk_int = 0, rst_int_n = 0;
    logic [47:0] mac_address = MAC;
    logic promiscuous = 0, irq_en = 0, rd_en = 0, release_req = 0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic [SLOT_W-1:0] len_idx = '0, head, tail;
    logic [15:0] len_data, drop_full, drop_filter, drop_err;
    logic [SLOT_W:0] count;
    logic irq;

    eth_rx_ring_if s_axis();

    eth_rx_ring #(.NBUF(NBUF), .BUF_BYTES(BUF_BYTES), .DATA_W(DATA_W)) dut (
        .clk_int(clk_int), .rst_int_n(rst_int_n), .s_axis(s_axis),
        .mac_address(mac_address), .promiscuous(promiscuous), .irq_en(irq_en),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .len_idx(len_idx), .len_data(len_data), .release_req(release_req),
        .head(head), .tail(tail), .count(count), .irq(irq),
        .drop_full(drop_full), .drop_filter(drop_filter), .drop_err(drop_err));

    always #5 clk_int = ~clk_int;

    int errors = 0, checks = 0;

    // Reference model: whole-frame view of the ring.
    logic [7:0] m_mem [NBUF][BUF_BYTES];
    int m_len [NBUF];
    int m_head, m_tail, m_count, m_dfull, m_dfilt, m_derr;

    function automatic void model_clear();
        m_head = 0; m_tail = 0; m_count = 0; m_dfull = 0; m_dfilt = 0; m_derr = 0;
        for (int i = 0; i < NBUF; i++) m_len[i] = 0;
    endfunction

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    function automatic void model_frame(input logic [7:0] frm[$], input bit user);
        logic [47:0] d;
        int n = frm.size();
        if (m_count == NBUF) begin m_dfull = sat(m_dfull); return; end
        if (n < 6) begin m_derr = sat(m_derr); return; end
        d = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
        if (!(promiscuous || d == mac_address || d == 48'hFFFF_FFFF_FFFF || d[47:24] == 24'h01005E))
            m_dfilt = sat(m_dfilt);
        else if (user || n > BUF_BYTES)
            m_derr = sat(m_derr);
        else begin
            for (int i = 0; i < n; i++) m_mem[m_tail][i] = frm[i];
            m_len[m_tail] = n;
            m_tail = (m_tail + 1) % NBUF;
            m_count++;
        end
    endfunction

    function automatic void model_release();
        if (m_count != 0) begin m_head = (m_head + 1) % NBUF; m_count--; end
    endfunction

    function automatic logic [DATA_W-1:0] model_word(input int s, input int w, output logic [DATA_W-1:0] mask);
        logic [DATA_W-1:0] v = '0;
        mask = '0;
        for (int j = 0; j < 8; j++)
            if (w * 8 + j < m_len[s]) begin
                v[j*8 +: 8] = m_mem[s][w*8+j];
                mask[j*8 +: 8] = 8'hFF;
            end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_int); #1;
    endtask

    task automatic drive_byte(input logic [7:0] b, input bit last, input bit user, input bit gap, output bit ok);
        if (gap) begin s_axis.tvalid = 0; tick(); end
        s_axis.tdata = b; s_axis.tlast = last; s_axis.tuser = user; s_axis.tvalid = 1;
        ok = 0;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk_int); ok = s_axis.tready;
            tick();
        end
        s_axis.tvalid = 0; s_axis.tlast = 0; s_axis.tuser = 0;
    endtask

    task automatic send_frame(input logic [47:0] dest, input int n, input bit user, input int abort_at, input bit gaps);
        logic [7:0] frm[$];
        bit ok;
        for (int i = 0; i < n; i++) frm.push_back(i < 6 ? dest[8*(5-i) +: 8] : 8'($urandom));
        for (int i = 0; i < n; i++) begin
            if (abort_at >= 0 && i == abort_at) return;
            drive_byte(frm[i], i == n - 1, user && (i == n - 1), gaps && ($urandom_range(0, 3) == 0), ok);
            if (!ok) begin
                checks++; errors++;
                $display("FAIL tready_timeout: byte %0d of %0d never accepted, want accept within 64 cycles", i, n);
                return;
            end
        end
        model_frame(frm, user);
    endtask

    task automatic pulse_release();
        release_req = 1; tick(); release_req = 0;
        model_release();
    endtask

    task automatic read_word(input int a, output logic [DATA_W-1:0] d);
        rd_addr = ADDR_W'(a); rd_en = 1; tick(); rd_en = 0; d = rd_data;
    endtask

    task automatic read_len(input int idx, output logic [15:0] l);
        len_idx = SLOT_W'(idx); tick(); l = len_data;
    endtask

    task automatic do_reset();
        s_axis.tvalid = 0; s_axis.tlast = 0; s_axis.tuser = 0; s_axis.tdata = 0;
        rd_en = 0; release_req = 0; rst_int_n = 0;
        repeat (2) tick();
        rst_int_n = 1; tick();
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({head, tail, count, irq, drop_full, drop_filter, drop_err, rd_data, len_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: head=%0d tail=%0d count=%0d irq=%b drops=%0d/%0d/%0d rd=%h len=%0d, want all 0",
                     head, tail, count, irq, drop_full, drop_filter, drop_err, rd_data, len_data);
        end
        checks++;
        if (s_axis.tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b want 1", s_axis.tready); end
    endtask

    task automatic test_first_frame();
        logic [DATA_W-1:0] d, e, m, d2;
        logic [15:0] l;
        do_reset();
        irq_en = 1;
        send_frame(MAC, 64, 0, -1, 1);
        tick();
        checks++;
        if (count !== 4'd1 || tail !== 3'd1 || irq !== 1'b0) begin
            errors++; $display("FAIL commit_cycle: count=%0d tail=%0d irq=%b, want 1 1 0", count, tail, irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b want 1", irq); end
        read_len(0, l);
        checks++;
        if (l !== 16'd64) begin errors++; $display("FAIL len_first: got %0d want 64", l); end
        for (int w = 0; w < 8; w++) begin
            read_word(w, d);
            e = model_word(0, w, m);
            checks++;
            if ((d & m) !== (e & m)) begin errors++; $display("FAIL word_first[%0d]: got %h want %h", w, d, e); end
        end
        read_word(0, d);
        repeat (3) tick();
        d2 = rd_data;
        checks++;
        if (d2 !== d) begin errors++; $display("FAIL rd_hold: got %h want %h", d2, d); end
        irq_en = 0; tick();
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b want 0", irq); end
    endtask

    task automatic test_filter();
        do_reset();
        promiscuous = 0;
        send_frame(48'h0A0B0C0D0E0F, 60, 0, -1, 0);
        repeat (2) tick();
        checks++;
        if (drop_filter !== 16'd1 || count !== 4'd0) begin
            errors++; $display("FAIL filter_reject: drop_filter=%0d count=%0d want 1 0", drop_filter, count);
        end
        promiscuous = 1;
        send_frame(48'h0A0B0C0D0E0F, 60, 0, -1, 0);
        promiscuous = 0;
        send_frame(48'hFFFF_FFFF_FFFF, 70, 0, -1, 1);
        send_frame({24'h01005E, 24'($urandom)}, 80, 0, -1, 1);
        repeat (2) tick();
        checks++;
        if (count !== 4'(m_count) || m_count != 3 || drop_filter !== 16'(m_dfilt)) begin
            errors++; $display("FAIL filter_accept: count=%0d drop_filter=%0d want %0d %0d", count, drop_filter, m_count, m_dfilt);
        end
    endtask

    task automatic test_full();
        logic [DATA_W-1:0] d, e, m;
        logic [15:0] l;
        do_reset();
        for (int f = 0; f < 9; f++) send_frame(MAC, 64 + f, 0, -1, 0);
        repeat (2) tick();
        checks++;
        if (count !== 4'd8 || drop_full !== 16'd1 || tail !== 3'd0) begin
            errors++; $display("FAIL ring_full: count=%0d drop_full=%0d tail=%0d want 8 1 0", count, drop_full, tail);
        end
        pulse_release();
        tick();
        checks++;
        if (head !== 3'd1 || count !== 4'd7) begin
            errors++; $display("FAIL full_release: head=%0d count=%0d want 1 7", head, count);
        end
        send_frame(MAC, 100, 0, -1, 1);
        repeat (2) tick();
        read_len(0, l);
        checks++;
        if (l !== 16'd100 || tail !== 3'd1 || count !== 4'd8) begin
            errors++; $display("FAIL wrap_slot0: len=%0d tail=%0d count=%0d want 100 1 8", l, tail, count);
        end
        read_word(1, d);
        e = model_word(0, 1, m);
        checks++;
        if ((d & m) !== (e & m)) begin errors++; $display("FAIL wrap_data: got %h want %h", d, e); end
    endtask

    task automatic test_errors();
        logic [15:0] l;
        logic [DATA_W-1:0] d, e, m;
        do_reset();
        send_frame(MAC, 50, 1, -1, 1);
        send_frame(MAC, 4, 0, -1, 0);
        send_frame(MAC, 2100, 0, -1, 0);
        repeat (2) tick();
        checks++;
        if (drop_err !== 16'd3 || count !== 4'd0 || s_axis.tready !== 1'b1) begin
            errors++; $display("FAIL err_drops: drop_err=%0d count=%0d tready=%b want 3 0 1", drop_err, count, s_axis.tready);
        end
        send_frame(MAC, BUF_BYTES, 0, -1, 0);
        repeat (2) tick();
        read_len(0, l);
        checks++;
        if (l !== 16'(BUF_BYTES) || count !== 4'd1 || drop_err !== 16'd3) begin
            errors++; $display("FAIL max_frame: len=%0d count=%0d drop_err=%0d want %0d 1 3", l, count, drop_err, BUF_BYTES);
        end
        read_word(WPS - 1, d);
        e = model_word(0, WPS - 1, m);
        checks++;
        if ((d & m) !== (e & m)) begin errors++; $display("FAIL max_frame_tail: got %h want %h", d, e); end
    endtask

    task automatic test_release_commit();
        do_reset();
        for (int f = 0; f < 3; f++) send_frame(MAC, 40, 0, -1, 0);
        repeat (2) tick();
        send_frame(MAC, 40, 0, -1, 0);
        pulse_release();
        tick();
        checks++;
        if (count !== 4'd3 || head !== 3'd1 || tail !== 3'd4 || m_count != 3) begin
            errors++; $display("FAIL release_in_commit: count=%0d head=%0d tail=%0d want 3 1 4", count, head, tail);
        end
        repeat (3) pulse_release();
        pulse_release();
        tick();
        checks++;
        if (count !== 4'd0 || head !== 3'(m_head) || m_head != 4) begin
            errors++; $display("FAIL release_empty: count=%0d head=%0d want 0 %0d", count, head, m_head);
        end
    endtask

    task automatic test_random();
        logic [47:0] dst;
        logic [DATA_W-1:0] d, e, m;
        logic [15:0] l;
        int n, s;
        do_reset();
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 4))
                0: dst = 48'hFFFF_FFFF_FFFF;
                1: dst = {24'h01005E, 24'($urandom)};
                2: dst = {16'h0A0B, 32'($urandom)};
                default: dst = MAC;
            endcase
            promiscuous = ($urandom_range(0, 7) == 0);
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 5) : $urandom_range(14, 200);
            s = m_tail;
            send_frame(dst, n, $urandom_range(0, 9) == 0, -1, 1);
            repeat (2) tick();
            checks++;
            if ({count, head, tail} !== {4'(m_count), 3'(m_head), 3'(m_tail)} ||
                {drop_full, drop_filter, drop_err} !== {16'(m_dfull), 16'(m_dfilt), 16'(m_derr)}) begin
                errors++;
                $display("FAIL rand_state[%0d]: cnt=%0d h=%0d t=%0d drops=%0d/%0d/%0d want %0d %0d %0d %0d/%0d/%0d",
                         f, count, head, tail, drop_full, drop_filter, drop_err,
                         m_count, m_head, m_tail, m_dfull, m_dfilt, m_derr);
            end
            if (s != m_tail) begin
                read_len(s, l);
                checks++;
                if (l !== 16'(m_len[s])) begin errors++; $display("FAIL rand_len[%0d]: got %0d want %0d", f, l, m_len[s]); end
                for (int w = 0; w < 3; w++) begin
                    read_word(s * WPS + w, d);
                    e = model_word(s, w, m);
                    checks++;
                    if ((d & m) !== (e & m)) begin errors++; $display("FAIL rand_word[%0d.%0d]: got %h want %h", f, w, d, e); end
                end
            end
            if ($urandom_range(0, 2) == 0) pulse_release();
        end
        promiscuous = 0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] l;
        logic [DATA_W-1:0] d, e, m;
        do_reset();
        send_frame(MAC, 64, 0, -1, 0);
        repeat (2) tick();
        send_frame(MAC, 64, 0, 20, 0);
        read_word(0, d);
        rst_int_n = 0; #1;
        checks++;
        if ({head, tail, count, irq, drop_full, drop_filter, drop_err, rd_data, len_data} !== '0) begin
            errors++; $display("FAIL reset_mid: head=%0d tail=%0d count=%0d rd=%h len=%0d, want all 0",
                               head, tail, count, rd_data, len_data);
        end
        tick(); rst_int_n = 1; tick();
        model_clear();
        send_frame(MAC, 77, 0, -1, 1);
        repeat (2) tick();
        read_len(0, l);
        checks++;
        if (l !== 16'd77 || tail !== 3'd1 || count !== 4'd1) begin
            errors++; $display("FAIL after_reset: len=%0d tail=%0d count=%0d want 77 1 1", l, tail, count);
        end
        read_word(0, d);
        e = model_word(0, 0, m);
        checks++;
        if (d !== e) begin errors++; $display("FAIL after_reset_data: got %h want %h", d, e); end
    endtask

    initial begin
        s_axis.tvalid = 0; s_axis.tlast = 0; s_axis.tuser = 0; s_axis.tdata = 0;
        model_clear();
        #2;
        test_reset();
        test_first_frame();
        test_filter();
        test_full();
        test_errors();
        test_release_commit();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL global_timeout: simulation did not finish, want completion");
        $fatal(1);
    end
endmodule
